// File: rtl/alctrl_ram_init_seq_pkg.sv
// Shared types and constants for the active-list control RAM init sequencer.
package alctrl_ram_init_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StReady
   } alctrl_init_state_t;

   localparam int unsigned RAM_RESET_ZERO = 0;

   function automatic int unsigned part_depth(input int unsigned depth,
                                              input int unsigned parts);
      return depth / parts;
   endfunction

endpackage

// File: rtl/alctrl_ram_init_seq_lsb_enc.sv
// Priority encoder: index of the lowest set request bit, plus an any-set flag.
module lowest_set_bit_enc #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            idx_o   = IDX_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alctrl_ram_init_seq.sv
// Clears active-list control RAM partitions after reset, on partition power-up
// and on a recovery re-clear request, one entry per cycle; gates dispatch meanwhile.
module alctrl_ram_init_seq
   import alctrl_ram_init_seq_pkg::*;
#(
   parameter int unsigned      DEPTH         = 16,
   parameter int unsigned      INDEX         = 4,
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      NUM_PARTS     = 4,
   parameter int unsigned      NUM_PARTS_LOG = 2,
   parameter logic [WIDTH-1:0] INIT_VAL      = WIDTH'(RAM_RESET_ZERO)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PARTS-1:0] alPartitionActive_i,
   input  logic                 clearReq_i,
   output logic                 initWe_o,
   output logic [INDEX-1:0]     initAddr_o,
   output logic [WIDTH-1:0]     initData_o,
   output logic                 alCtrlReady_o,
   output logic                 clearBusy_o
);

   localparam int unsigned PART_DEPTH = part_depth(DEPTH, NUM_PARTS);
   localparam int unsigned OFF_W      = INDEX - NUM_PARTS_LOG;

   alctrl_init_state_t       state_q, state_d;
   logic [NUM_PARTS-1:0]     pend_q, pend_d, prev_active_q;
   logic [NUM_PARTS-1:0]     pend_next, pend_upd;
   logic [NUM_PARTS_LOG-1:0] cur_part_q, cur_part_d, nxt_part;
   logic [OFF_W-1:0]         offset_q, offset_d;
   logic                     ready_q, ready_d;
   logic                     offset_last, part_done, nxt_valid;

   assign offset_last = (offset_q == OFF_W'(PART_DEPTH - 1));

   always_comb begin
      pend_next = ((clearReq_i ? alPartitionActive_i : pend_q)
                   | (alPartitionActive_i & ~prev_active_q)) & alPartitionActive_i;
      part_done = (state_q == StClear) && !clearReq_i && pend_next[cur_part_q] && offset_last;
      pend_upd  = pend_next;
      if (part_done) pend_upd[cur_part_q] = 1'b0;
   end

   lowest_set_bit_enc #(
      .NUM_REQ (NUM_PARTS),
      .IDX_W   (NUM_PARTS_LOG)
   ) u_next_part (
      .req_i   (pend_upd),
      .idx_o   (nxt_part),
      .valid_o (nxt_valid)
   );

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_upd;
      cur_part_d = cur_part_q;
      offset_d   = offset_q;
      ready_d    = ready_q;
      unique case (state_q)
         StIdle: begin
            cur_part_d = nxt_part;
            offset_d   = '0;
            if (nxt_valid) begin
               state_d = StClear;
            end else begin
               state_d = StReady;
               ready_d = 1'b1;
            end
         end
         StClear: begin
            // Restart, abort of a powered-down partition, or end of partition.
            if (clearReq_i || !pend_next[cur_part_q] || offset_last) begin
               offset_d   = '0;
               cur_part_d = nxt_part;
            end else begin
               offset_d = offset_q + OFF_W'(1);
            end
            if (!nxt_valid) begin
               state_d = StReady;
               ready_d = 1'b1;
            end
         end
         StReady: begin
            if (nxt_valid) begin
               state_d    = StClear;
               ready_d    = 1'b0;
               cur_part_d = nxt_part;
               offset_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         pend_q        <= '0;
         prev_active_q <= '0;
         cur_part_q    <= '0;
         offset_q      <= '0;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         prev_active_q <= alPartitionActive_i;
         cur_part_q    <= cur_part_d;
         offset_q      <= offset_d;
         ready_q       <= ready_d;
      end
   end

   // A partition dropped mid-clear is not written in the cycle it disappears.
   assign initWe_o      = (state_q == StClear) && pend_q[cur_part_q] && pend_next[cur_part_q];
   assign initAddr_o    = {cur_part_q, offset_q};
   assign initData_o    = INIT_VAL;
   assign alCtrlReady_o = ready_q;
   assign clearBusy_o   = (state_q == StClear);

endmodule

// File: tb/tb_alctrl_ram_init_seq.sv
// Directed bench for alctrl_ram_init_seq: sweeps, power-up, abort, re-clear, reset.
module tb_alctrl_ram_init_seq;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] active = 4'b0000;
   logic       clear_req = 1'b0;
   logic       we;
   logic [3:0] addr;
   logic [7:0] data;
   logic       ready;
   logic       busy;

   int checks = 0;
   int fails  = 0;

   alctrl_ram_init_seq dut (
      .clk                 (clk),
      .reset               (reset),
      .alPartitionActive_i (active),
      .clearReq_i          (clear_req),
      .initWe_o            (we),
      .initAddr_o          (addr),
      .initData_o          (data),
      .alCtrlReady_o       (ready),
      .clearBusy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Expect n consecutive write cycles starting at address base.
   task automatic sweep(input int base, input int n);
      for (int k = 0; k < n; k++) begin
         chk("sweep_we", {31'd0, we}, 32'd1);
         chk("sweep_addr", {28'd0, addr}, base + k);
         chk("sweep_ready", {31'd0, ready}, 32'd0);
         chk("sweep_busy", {31'd0, busy}, 32'd1);
         cyc();
      end
   endtask

   task automatic idle_ready();
      chk("ready", {31'd0, ready}, 32'd1);
      chk("ready_we", {31'd0, we}, 32'd0);
      chk("ready_busy", {31'd0, busy}, 32'd0);
   endtask

   // Ends at the negedge of cycle 1 (just after the first edge out of reset).
   task automatic do_reset(input logic [3:0] a);
      cyc();
      reset = 1'b1;
      active = a;
      clear_req = 1'b0;
      #1;
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_addr", {28'd0, addr}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   initial begin
      // Full sweep of all four partitions.
      do_reset(4'b1111);
      chk("init_data", {24'd0, data}, 32'd0);
      sweep(0, 16);
      idle_ready();
      cyc();
      idle_ready();

      // Sparse mask: partitions 0 and 2 only.
      do_reset(4'b0101);
      sweep(0, 4);
      sweep(8, 4);
      idle_ready();

      // No active partitions: ready on the first edge, no writes.
      do_reset(4'b0000);
      idle_ready();

      // Power up partition 1 while ready.
      do_reset(4'b0001);
      sweep(0, 4);
      idle_ready();
      active = 4'b0011;
      cyc();
      sweep(4, 4);
      idle_ready();

      // Re-clear request while ready.
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      sweep(0, 8);
      idle_ready();

      // Re-clear request at offset 2 of partition 1 restarts at address 0.
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      sweep(0, 6);
      chk("restart_pre_addr", {28'd0, addr}, 32'd6);
      clear_req = 1'b1;
      cyc();
      clear_req = 1'b0;
      sweep(0, 8);
      idle_ready();

      // Partition 2 dropped at offset 1: no more writes there, moves on to 3.
      do_reset(4'b1101);
      sweep(0, 4);
      sweep(8, 1);
      chk("abort_addr", {28'd0, addr}, 32'd9);
      active = 4'b1001;
      #1;
      chk("abort_we", {31'd0, we}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd1);
      cyc();
      sweep(12, 4);
      idle_ready();

      // Reset at sweep cycle 5, then a full identical sweep.
      do_reset(4'b1111);
      sweep(0, 4);
      chk("midrst_pre_addr", {28'd0, addr}, 32'd4);
      reset = 1'b1;
      #1;
      chk("midrst_we", {31'd0, we}, 32'd0);
      chk("midrst_addr", {28'd0, addr}, 32'd0);
      chk("midrst_ready", {31'd0, ready}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      cyc();
      reset = 1'b0;
      cyc();
      sweep(0, 16);
      idle_ready();

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
